fpu_add_sched: RTL



---
 rtl/fpu_add_sched_if.sv | 26 ++
 rtl/fpu_add_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_sched_if.sv
// Request/response bundle shared by the requesters, the result consumer and the FP add scheduler.
// Operand and op buses pack requester i at [64i+:64] and [3i+:3] ({tbl,rnd,m}).
interface fpu_add_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [64*NREQ-1:0] req_a;
   logic [64*NREQ-1:0] req_b;
   logic [3*NREQ-1:0]  req_op;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [63:0]        rsp_data;
   logic [IDW-1:0]     rsp_id;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/fpu_add_sched.sv
// Round-robin issue scheduler and tagged, credit-limited result collector for the shared FP add/table unit.
// Defining FPU_SCHED_FLUSH_EN adds a flush input that discards every in-flight op and queued result.

module fpu_add_sched_chk #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic            clk,
   input logic            rst,
   input logic            push,
   input logic [CW-1:0]   cnt,
   input logic [NREQ-1:0] ready
);
   no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && (cnt == CW'(DEPTH))));
   grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ready));
endmodule

module fpu_add_sched #(
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int IDW   = 2
) (
   input  logic           clk,
   input  logic           rst,
`ifdef FPU_SCHED_FLUSH_EN
   input  logic           flush,
`endif
   fpu_add_sched_if.slave bus,
   output logic [63:0]    fpu_a,
   output logic [63:0]    fpu_b,
   output logic           fpu_rnd,
   output logic           fpu_pookm,
   output logic           fpu_pookg,
   input  logic [63:0]    fpu_res,
   output logic           busy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(LAT + DEPTH + 2) + 1;

   logic [IDW-1:0]  ptr_r;
   logic [63:0]     hold_a_r;
   logic [63:0]     hold_b_r;
   logic            hold_rnd_r;
   logic            hold_m_r;
   logic [LAT-1:0]  pipe_vld_r;
   logic [LAT-1:0]  pipe_tbl_r;
   logic [IDW-1:0]  pipe_id_r [LAT];
   logic [63:0]     mem_data_r [DEPTH];
   logic [IDW-1:0]  mem_id_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   cnt_r;

   logic            flush_s;
   logic            found_s;
   logic [IDW-1:0]  win_s;
   logic [63:0]     win_a_s;
   logic [63:0]     win_b_s;
   logic [2:0]      win_op_s;
   logic [SW-1:0]   inflight_s;
   logic            credit_s;
   logic            grant_s;
   logic            push_s;
   logic            pop_s;
   logic [NREQ-1:0] rdy_s;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         ptr_inc = '0;
      end else begin
         ptr_inc = p + AW'(1);
      end
   endfunction

`ifdef FPU_SCHED_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Round-robin search: first pass from the pointer upward, second pass wraps below it.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found_s && bus.req_valid[i] && (IDW'(i) >= ptr_r)) begin
            found_s = 1'b1;
            win_s   = IDW'(i);
         end else begin
            found_s = found_s;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found_s && bus.req_valid[i] && (IDW'(i) < ptr_r)) begin
            found_s = 1'b1;
            win_s   = IDW'(i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Operand/op mux for the current winner.
   always_comb begin
      win_a_s  = '0;
      win_b_s  = '0;
      win_op_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == win_s) begin
            win_a_s  = bus.req_a[64*i +: 64];
            win_b_s  = bus.req_b[64*i +: 64];
            win_op_s = bus.req_op[3*i +: 3];
         end else begin
            win_op_s = win_op_s;
         end
      end
   end

   // Number of ops currently travelling through the unit.
   always_comb begin
      inflight_s = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight_s = inflight_s + SW'(pipe_vld_r[i]);
      end
   end

   assign push_s   = pipe_vld_r[LAT-1];
   assign pop_s    = (cnt_r != '0) && bus.rsp_ready;
   // A same-cycle pop frees a FIFO slot, so it widens the credit window by one.
   assign credit_s = (inflight_s + SW'(cnt_r) + SW'(1)) <= (SW'(DEPTH) + SW'(pop_s));
   assign grant_s  = found_s && credit_s && !flush_s && !rst;

   // One-hot ready for the winner only.
   always_comb begin
      rdy_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         rdy_s[i] = grant_s && (IDW'(i) == win_s);
      end
   end

   assign bus.req_ready = rdy_s;

   // Unit pins follow the winner on a grant and otherwise hold the last issued values.
   assign fpu_a     = grant_s ? win_a_s     : hold_a_r;
   assign fpu_b     = grant_s ? win_b_s     : hold_b_r;
   assign fpu_rnd   = grant_s ? win_op_s[1] : hold_rnd_r;
   assign fpu_pookm = grant_s ? win_op_s[0] : hold_m_r;
   assign fpu_pookg = pipe_tbl_r[LAT-1];

   // Round-robin pointer and operand hold registers advance only on a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r      <= '0;
         hold_a_r   <= '0;
         hold_b_r   <= '0;
         hold_rnd_r <= 1'b0;
         hold_m_r   <= 1'b0;
      end else if (grant_s) begin
         ptr_r      <= (win_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : win_s + IDW'(1);
         hold_a_r   <= win_a_s;
         hold_b_r   <= win_b_s;
         hold_rnd_r <= win_op_s[1];
         hold_m_r   <= win_op_s[0];
      end
   end

   // Shadow pipeline tracking {valid,id,tbl} of each op inside the unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld_r <= '0;
         pipe_tbl_r <= '0;
         for (int i = 0; i < LAT; i++) begin
            pipe_id_r[i] <= '0;
         end
      end else if (flush_s) begin
         pipe_vld_r <= '0;
         pipe_tbl_r <= '0;
      end else begin
         pipe_vld_r[0] <= grant_s;
         pipe_tbl_r[0] <= grant_s && win_op_s[2];
         pipe_id_r[0]  <= win_s;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld_r[i] <= pipe_vld_r[i-1];
            pipe_tbl_r[i] <= pipe_tbl_r[i-1];
            pipe_id_r[i]  <= pipe_id_r[i-1];
         end
      end
   end

   // Result FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else if (flush_s) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1);
            2'b01:   cnt_r <= cnt_r - CW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // FIFO storage; payload is qualified by the count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_data_r[wr_ptr_r] <= fpu_res;
         mem_id_r[wr_ptr_r]   <= pipe_id_r[LAT-1];
      end
   end

   assign bus.rsp_valid = (cnt_r != '0);
   assign bus.rsp_data  = mem_data_r[rd_ptr_r];
   assign bus.rsp_id    = mem_id_r[rd_ptr_r];
   assign busy          = (|pipe_vld_r) || (cnt_r != '0);

   fpu_add_sched_chk #(.NREQ(NREQ), .DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .cnt   (cnt_r),
      .ready (rdy_s)
   );
endmodule
